// File: rtl/spi_frame_receiver.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_receiver
// Purpose  : Oversampling SPI frame receiver. It takes in W_IN-bit frames
//            MSB first on rising spi_clock while cs_n is low, and presents
//            each complete frame on a valid/ready port. Frames with the wrong
//            bit count are flagged, and so are complete frames that are
//            dropped because the output holding register is full.
// Options  : `define SPI_FRAME_RX_ERR_CNT_EN adds err_count / err_clr.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_receiver #(
  parameter int W_IN        = 24,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            spi_clock,
  input  logic            spi_data,
  input  logic            cs_n,
  output logic [W_IN-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
`ifdef SPI_FRAME_RX_ERR_CNT_EN
  ,
  output logic [7:0]      err_count,
  input  logic            err_clr
`endif
);

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(W_IN);
  localparam logic [CNT_W-1:0] C_CNT_SAT  = CNT_W'(W_IN + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [SYNC_STAGES-1:0] r_fill;     // marks when the sync chain holds real pin samples
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic                   r_armed;    // cs_n has been seen high since reset
  logic                   r_cs_fall;
  logic                   r_cs_rise;
  logic                   r_sck_rise;
  logic                   r_bit;

  state_t                 r_state;
  logic [W_IN-1:0]        r_shreg;
  logic [CNT_W-1:0]       r_bit_cnt;

  logic                   w_cs_s;
  logic                   w_sck_s;
  logic                   w_dat_s;

  assign w_cs_s  = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];

  // Synchronize the pins, detect edges, and register the edge pulses with the aligned data bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_sync  <= '1;
      r_sck_sync <= '0;
      r_dat_sync <= '0;
      r_fill     <= '0;
      r_cs_d     <= 1'b1;
      r_sck_d    <= 1'b0;
      r_armed    <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_sck_rise <= 1'b0;
      r_bit      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_clock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], spi_data};
      r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
      r_cs_d     <= w_cs_s;
      r_sck_d    <= w_sck_s;
      // The reset value of the cs_n chain is not a real observation, so it
      // must not arm the receiver. Only a genuine high sample counts.
      if (r_fill[SYNC_STAGES-1] && w_cs_s) begin
        r_armed <= 1'b1;
      end
      r_cs_fall  <= r_armed & ~w_cs_s & r_cs_d;
      r_cs_rise  <= r_armed & w_cs_s & ~r_cs_d;
      r_sck_rise <= w_sck_s & ~r_sck_d;
      r_bit      <= w_dat_s;
      busy       <= r_armed & ~w_cs_s;
    end
  end

  // Frame FSM: shift bits while selected, then commit or flag on deselect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          if (r_cs_fall) begin
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (r_sck_rise) begin
            r_shreg <= {r_shreg[W_IN-2:0], r_bit};
            if (r_bit_cnt != C_CNT_SAT) begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end
          if (r_cs_rise) begin
            r_state <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (r_bit_cnt == C_CNT_FULL) begin
            // A consume in this same cycle frees the holding register
            if (!out_valid || out_ready) begin
              out_data  <= r_shreg;
              out_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else if (r_bit_cnt != '0) begin
            frame_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_FRAME_RX_ERR_CNT_EN
  // Saturating error tally; a clear takes priority over a coincident error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if ((frame_err || overrun) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
Receive side of the SPI link that the controller's SPI master drives.
- Sits at the IRS tile end of the link (and in benches, as the loopback sink).
- Oversamples cs_n / spi_clock / spi_data on the local clock and shifts in W_IN-bit frames, MSB first, sampling on rising spi_clock.
- Presents each complete frame on a valid/ready output port.
- Flags malformed frames (wrong bit count) and overruns.

Parameters:
W_IN, 24, frame width in bits; a frame is valid only if exactly W_IN rising spi_clock edges occur while cs_n is low.
SYNC_STAGES, 2, synchronizer depth for cs_n, spi_clock and spi_data (legal values 2..3).
CNT_W, 5, bit counter width; must satisfy 2^CNT_W > W_IN.

Ports:
clk  in  1  system clock (50 MHz); SPI half-period must be at least SYNC_STAGES+1 clk cycles.
rst_n  in  1  reset, asynchronous assert, active-low.
spi_clock  in  1  serial clock from master, idle low, asynchronous to clk.
spi_data  in  1  serial data, MSB first, stable around rising spi_clock.
cs_n  in  1  chip select, active-low; frame boundary.
out_data  out  W_IN  last committed frame.
out_valid  out  1  out_data holds an unconsumed frame.
out_ready  in  1  consumer accepts out_data when out_valid && out_ready at a clk edge.
frame_err  out  1  one-cycle pulse: frame ended with a bit count other than W_IN (nonzero).
overrun  out  1  one-cycle pulse: complete frame dropped because the holding register was full.
busy  out  1  high while synchronized cs_n is low.

Behaviour:
Reset values:
- out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
- Shift register, bit counter and all synchronizer stages clear.
- Synchronizer stages for cs_n reset to 1 (inactive).

Input conditioning:
- All three inputs pass through SYNC_STAGES flops.
- Edge detection compares the last sync stage with one extra delayed flop.
- Data and clock share identical sync depth, so sampled data is aligned to the detected rising spi_clock.

State machine: IDLE, SHIFT, COMMIT.
- IDLE: wait for cs_n falling (synchronized). On fall: bit_cnt=0, shreg=0, enter SHIFT.
- SHIFT, each rising spi_clock: shreg={shreg[W_IN-2:0], data}. bit_cnt increments, saturating at W_IN+1.
- SHIFT, cs_n rising: enter COMMIT.
- SHIFT, cs_n falling again (cannot occur without an intervening rise) is ignored.
- COMMIT lasts one cycle, then returns to IDLE.
  - bit_cnt==W_IN, with !out_valid or out_ready this cycle: out_data<=shreg, out_valid<=1.
  - bit_cnt==W_IN with out_valid && !out_ready: overrun pulse; the old word is retained and the new word is dropped.
  - bit_cnt==0: silent. This is a CS glitch, with no error and no valid.
  - Any other count, including W_IN+1 (long frame): frame_err pulse; out_data and out_valid are unchanged.

Handshake:
- out_valid clears on a clk edge with out_ready=1, unless a commit loads in the same cycle. In that case it stays 1 with the new data and no overrun.
- out_data is stable while out_valid=1 and not consumed.

Latency:
- Counted from the first clk edge that samples cs_n high at the pin: out_valid rises SYNC_STAGES+2 cycles later, which is 4 at the defaults.
- frame_err and overrun use the same timing.

busy:
- Equals the inverted last cs_n sync stage, registered.

Back-to-back frames:
- cs_n high for 5 clk (master CS_INACTIVE_CYCLES) must be accepted; COMMIT completes before the next fall is detected.

Async reset mid-frame:
- Discards the partial frame and all state.
- After release, the block waits for a fresh cs_n fall. A frame already in progress at release produces no output: busy and capture are inhibited until cs_n has been seen high at least once.

spi_clock edges while cs_n is high are ignored.

Optional Feature:
Macro SPI_FRAME_RX_ERR_CNT_EN.
- Defined:
  - Adds output err_count (8 bits, reset 0), incremented on every frame_err or overrun pulse, saturating at 255.
  - Adds input err_clr (1 bit), which synchronously clears it. If err_clr and an increment coincide, the clear wins.
- Undefined: neither port exists and no counter logic is built. All other behaviour is identical.

Test Plan:
- Reset, then one 24-bit frame 0x123456 MSB first, half-period 5 clk, out_ready=1 -> out_valid pulses one cycle with out_data=0x123456 four cycles after cs_n rise; frame_err=0.
- Frame of 16 bits 0xABCD, then cs_n high -> frame_err one-cycle pulse; out_valid stays 0; out_data unchanged.
- Frame of 25 bits -> frame_err pulse, no commit. A following correct frame 0x789ABC with a 5-clk CS gap -> out_data=0x789ABC.
- out_ready=0, send 0xDEF012 then 0x345678 -> out_data stays 0xDEF012, out_valid=1, overrun pulses once. Then out_ready=1 for one cycle -> out_valid=0.
- out_valid=1 holding 0x9ABCDE, and out_ready asserted exactly in the COMMIT cycle of frame 0xF01234 -> out_valid stays 1, out_data=0xF01234, overrun=0.
- Assert rst_n=0 after 10 bits of 0x567890, then release while cs_n is still low -> no out_valid and no frame_err for that frame; the next full frame 0xABCDEF is received correctly. With SPI_FRAME_RX_ERR_CNT_EN defined, run the earlier scenarios -> err_count=3; err_clr -> 0.
